// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the registered N-way selector (mux_pipe_n) and its
//   two-entry output buffer (skid_reg2).
//
//   Contents:
//     skid_state_e : occupancy state of the two-entry buffer
//     sel_width()  : select width derived from the channel count
//     is_pow2()    : true when every select code maps to a real channel
//
//   The per-entry struct {data, err} depends on the WIDTH parameter of the
//   instantiating module. A package typedef cannot take a parameter, so the
//   struct is declared inside mux_pipe_n using WIDTH. skid_reg2 takes it as a
//   type parameter.
// -----------------------------------------------------------------------------
package mux_pkg;

  // Buffer occupancy: nothing, head only, head plus skid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_e;

  // Select width for n channels. Never below 1 so the port always exists.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // With a power-of-two channel count every select code is a valid channel,
  // so the range check folds away to a constant.
  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/skid_reg2.sv
// -----------------------------------------------------------------------------
// skid_reg2
//   Two-entry in-order buffer with valid/ready on both sides. It is generic
//   over the stored entry type. The head entry sits in r_main and drives the
//   output directly. r_skid catches the one extra entry that can arrive while
//   the consumer stalls. o_ready depends only on the registered state, so the
//   producer never sees a combinational path from i_ready.
//
//   Ports:
//     clk      : rising-edge clock
//     rst_n    : asynchronous active-low reset; discards all entries
//     i_valid  : producer presents i_entry
//     o_ready  : buffer can accept this cycle (state != FULL)
//     i_entry  : entry to store
//     o_valid  : head entry valid (state != EMPTY)
//     i_ready  : consumer takes the head this cycle
//     o_entry  : head entry (r_main)
// -----------------------------------------------------------------------------
module skid_reg2
  import mux_pkg::*;
#(
  parameter type T = logic [32:0]
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_valid,
  output logic o_ready,
  input  T     i_entry,
  output logic o_valid,
  input  logic i_ready,
  output T     o_entry
);

  skid_state_e r_state;
  skid_state_e w_state_next;
  T            r_main;
  T            r_skid;
  logic        w_push;
  logic        w_pop;

  assign w_push = i_valid && o_ready;
  assign w_pop  = o_valid && i_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic. A push in FULL cannot happen because o_ready is low.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_push) w_state_next = ST_ONE;
      end
      ST_ONE: begin
        if (w_push && !w_pop)      w_state_next = ST_FULL;
        else if (!w_push && w_pop) w_state_next = ST_EMPTY;
      end
      ST_FULL: begin
        if (w_pop) w_state_next = ST_ONE;
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // Output logic: flags come from state only, and data comes from the head
  // register only.
  always_comb begin
    o_ready = (r_state != ST_FULL);
    o_valid = (r_state != ST_EMPTY);
    o_entry = r_main;
  end

  // Storage. r_main always holds the oldest entry, which gives FIFO order.
  // In ONE with push and pop together, the head leaves and the new entry
  // replaces it directly. In FULL with pop, the skid entry moves up to head.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_main <= '0;
      r_skid <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (w_push) r_main <= i_entry;
        end
        ST_ONE: begin
          if (w_push && w_pop) r_main <= i_entry;
          else if (w_push)     r_skid <= i_entry;
        end
        ST_FULL: begin
          if (w_pop) r_main <= r_skid;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/mux_pipe_n.sv
// -----------------------------------------------------------------------------
// mux_pipe_n
//   N-way, WIDTH-bit selector with a registered valid/ready output. The
//   selected word is stored together with an out-of-range flag in a
//   two-entry buffer, so the consumer may stall without losing data.
//
//   Parameters:
//     WIDTH : data width per channel
//     N     : number of channels (2 or more)
//     SEL_W : select width, derived from N
//
//   Ports:
//     clk          : rising-edge clock
//     rst_n        : asynchronous active-low reset
//     i_in_data    : N*WIDTH; channel k occupies [k*WIDTH +: WIDTH]
//     i_sel        : channel index, sampled with i_in_data
//     i_in_valid   : producer presents data/select
//     o_in_ready   : block can accept this cycle
//     o_out_data   : selected word at the head of the buffer
//     o_out_err    : head entry was captured with i_sel >= N
//     o_out_valid  : head entry valid
//     i_out_ready  : consumer takes the head this cycle
//     o_sel_err    : sticky flag for any accepted out-of-range select
//     i_err_clr    : synchronous clear of o_sel_err (a set in the same cycle wins)
// -----------------------------------------------------------------------------
module mux_pipe_n
  import mux_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int N     = 3,
  localparam int SEL_W = sel_width(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   i_in_data,
  input  logic [SEL_W-1:0]     i_sel,
  input  logic                 i_in_valid,
  output logic                 o_in_ready,
  output logic [WIDTH-1:0]     o_out_data,
  output logic                 o_out_err,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic                 o_sel_err,
  input  logic                 i_err_clr
);

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             err;
  } entry_t;

  logic [N-1:0]     w_hit;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_oor;
  logic             w_accept;
  entry_t           w_in_entry;
  entry_t           w_out_entry;
  logic             r_sel_err;

  // One-hot channel decode. An out-of-range select hits no channel, so the
  // OR-reduction below yields zero data without a separate masking step.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_hit
      assign w_hit[gi] = (i_sel == SEL_W'(gi));
    end
  endgenerate

  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (w_hit[k]) w_sel_data = w_sel_data | i_in_data[k*WIDTH +: WIDTH];
    end
  end

  // Range check. When N is a power of two, every code is valid. The compare
  // would also truncate N to zero in that case, so it is removed entirely.
  generate
    if (is_pow2(N)) begin : g_no_range
      assign w_oor = 1'b0;
    end else begin : g_range
      assign w_oor = (i_sel >= SEL_W'(N));
    end
  endgenerate

  always_comb begin
    w_in_entry      = '0;
    w_in_entry.data = w_sel_data;
    w_in_entry.err  = w_oor;
  end

  assign w_accept = i_in_valid && o_in_ready;

  // Sticky error flag. A set takes priority over a clear in the same cycle,
  // so an error arriving alongside a clear is never missed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && w_oor) begin
      r_sel_err <= 1'b1;
    end else if (i_err_clr) begin
      r_sel_err <= 1'b0;
    end
  end

  assign o_sel_err = r_sel_err;

  skid_reg2 #(
    .T (entry_t)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (i_in_valid),
    .o_ready (o_in_ready),
    .i_entry (w_in_entry),
    .o_valid (o_out_valid),
    .i_ready (i_out_ready),
    .o_entry (w_out_entry)
  );

  assign o_out_data = w_out_entry.data;
  assign o_out_err  = w_out_entry.err;

endmodule

// File: tb/tb_mux_pipe_n.sv
// -----------------------------------------------------------------------------
// tb_mux_pipe_n
//   Scoreboard bench for mux_pipe_n. The main process drives transfers and
//   pushes the expected {data, err} for every accepted entry. A monitor pops
//   and compares each entry the DUT hands over, and it checks that the head
//   holds while the consumer stalls. A second instance with N=4 covers the
//   power-of-two case.
// -----------------------------------------------------------------------------
module tb_mux_pipe_n;

  logic        clk;
  logic        rst_n;

  // N=3 instance
  logic [95:0] in_data;
  logic [1:0]  sel;
  logic        in_valid;
  logic        o_in_ready;
  logic [31:0] o_out_data;
  logic        o_out_err;
  logic        o_out_valid;
  logic        out_ready;
  logic        o_sel_err;
  logic        err_clr;

  // N=4 instance
  logic [127:0] in_data4;
  logic [1:0]   sel4;
  logic         in_valid4;
  logic         o_in_ready4;
  logic [31:0]  o_out_data4;
  logic         o_out_err4;
  logic         o_out_valid4;
  logic         out_ready4;
  logic         o_sel_err4;
  logic         err_clr4;

  typedef struct {
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t exp_q[$];

  int   checks    = 0;
  int   errors    = 0;
  int   pop_count = 0;

  mux_pipe_n #(.WIDTH(32), .N(3)) dut3 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_data   (in_data),
    .i_sel       (sel),
    .i_in_valid  (in_valid),
    .o_in_ready  (o_in_ready),
    .o_out_data  (o_out_data),
    .o_out_err   (o_out_err),
    .o_out_valid (o_out_valid),
    .i_out_ready (out_ready),
    .o_sel_err   (o_sel_err),
    .i_err_clr   (err_clr)
  );

  mux_pipe_n #(.WIDTH(32), .N(4)) dut4 (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_data   (in_data4),
    .i_sel       (sel4),
    .i_in_valid  (in_valid4),
    .o_in_ready  (o_in_ready4),
    .o_out_data  (o_out_data4),
    .o_out_err   (o_out_err4),
    .o_out_valid (o_out_valid4),
    .i_out_ready (out_ready4),
    .o_sel_err   (o_sel_err4),
    .i_err_clr   (err_clr4)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [95:0] w3(input logic [31:0] c2, input logic [31:0] c1,
                                     input logic [31:0] c0);
    return {c2, c1, c0};
  endfunction

  // Reference selection for the random phases: an out-of-range select gives
  // zero data.
  function automatic logic [31:0] pick(input logic [95:0] d, input logic [1:0] s);
    case (s)
      2'd0:    return d[31:0];
      2'd1:    return d[63:32];
      2'd2:    return d[95:64];
      default: return 32'd0;
    endcase
  endfunction

  // One cycle of producer activity, called at posedge+1. The accept decision
  // is sampled on the negedge, and the expected entry is queued if accepted.
  task automatic xfer(input logic v, input logic [95:0] d, input logic [1:0] s,
                      input logic [31:0] ed, input logic ee, output logic acc);
    in_valid = v;
    in_data  = d;
    sel      = s;
    @(negedge clk);
    acc = v && o_in_ready;
    if (acc) exp_q.push_back('{data: ed, err: ee});
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Monitor: compare every handed-over entry and check stability under stall.
  initial begin
    logic        prev_stall;
    logic [31:0] prev_data;
    logic        prev_err;
    exp_t        e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_err   = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          check("hold_data", {32'd0, o_out_data}, {32'd0, prev_data});
          check("hold_err", {63'd0, o_out_err}, {63'd0, prev_err});
        end
        if (o_out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pop: got data %08h with empty scoreboard, required no output",
                     o_out_data);
          end else begin
            e = exp_q.pop_front();
            pop_count++;
            $display("pop %0d data=%08h err=%0b exp_data=%08h exp_err=%0b",
                     pop_count, o_out_data, o_out_err, e.data, e.err);
            check("out_data", {32'd0, o_out_data}, {32'd0, e.data});
            check("out_err", {63'd0, o_out_err}, {63'd0, e.err});
          end
        end
        prev_stall = o_out_valid && !out_ready;
        prev_data  = o_out_data;
        prev_err   = o_out_err;
      end
    end
  end

  initial begin
    logic        acc;
    logic [1:0]  s;
    logic [95:0] d;
    int          drops;
    int          pops_before;

    rst_n     = 1'b0;
    in_data   = '0;
    sel       = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    err_clr   = 1'b0;
    in_data4  = '0;
    sel4      = '0;
    in_valid4 = 1'b0;
    out_ready4 = 1'b1;
    err_clr4  = 1'b0;

    // Reset state
    #12;
    check("rst_out_valid", {63'd0, o_out_valid}, 64'd0);
    check("rst_out_data", {32'd0, o_out_data}, 64'd0);
    check("rst_out_err", {63'd0, o_out_err}, 64'd0);
    check("rst_sel_err", {63'd0, o_sel_err}, 64'd0);
    check("rst4_out_valid", {63'd0, o_out_valid4}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("in_ready_after_rst", {63'd0, o_in_ready}, 64'd1);

    // Basic select: sel=1 of {30,20,10} gives 20 one cycle later
    out_ready = 1'b1;
    xfer(1'b1, w3(32'd30, 32'd20, 32'd10), 2'd1, 32'd20, 1'b0, acc);
    check("basic_out_valid", {63'd0, o_out_valid}, 64'd1);
    check("basic_out_data", {32'd0, o_out_data}, 64'd20);
    check("basic_out_err", {63'd0, o_out_err}, 64'd0);
    tick();
    check("basic_drained", {63'd0, o_out_valid}, 64'd0);

    // Back-pressure: two accepted, third refused while FULL
    out_ready = 1'b0;
    xfer(1'b1, w3(32'd30, 32'd20, 32'd10), 2'd0, 32'd10, 1'b0, acc);
    check("bp_acc0", {63'd0, acc}, 64'd1);
    xfer(1'b1, w3(32'd30, 32'd20, 32'd10), 2'd1, 32'd20, 1'b0, acc);
    check("bp_acc1", {63'd0, acc}, 64'd1);
    xfer(1'b1, w3(32'd30, 32'd20, 32'd10), 2'd2, 32'd30, 1'b0, acc);
    check("bp_acc2_refused", {63'd0, acc}, 64'd0);
    check("bp_in_ready_full", {63'd0, o_in_ready}, 64'd0);
    out_ready = 1'b1;
    tick();
    check("bp_in_ready_rises", {63'd0, o_in_ready}, 64'd1);
    xfer(1'b1, w3(32'd30, 32'd20, 32'd10), 2'd2, 32'd30, 1'b0, acc);
    check("bp_acc2_retry", {63'd0, acc}, 64'd1);
    tick();
    tick();
    check("bp_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Out-of-range select
    xfer(1'b1, w3(32'd30, 32'd20, 32'd10), 2'd3, 32'd0, 1'b1, acc);
    check("oor_out_data", {32'd0, o_out_data}, 64'd0);
    check("oor_out_err", {63'd0, o_out_err}, 64'd1);
    check("oor_sel_err", {63'd0, o_sel_err}, 64'd1);
    repeat (5) tick();
    check("oor_sel_err_sticky", {63'd0, o_sel_err}, 64'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("oor_sel_err_cleared", {63'd0, o_sel_err}, 64'd0);
    err_clr = 1'b1;
    xfer(1'b1, w3(32'd30, 32'd20, 32'd10), 2'd3, 32'd0, 1'b1, acc);
    err_clr = 1'b0;
    check("oor_set_beats_clear", {63'd0, o_sel_err}, 64'd1);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("oor_sel_err_cleared2", {63'd0, o_sel_err}, 64'd0);

    // Full throughput: 100 back-to-back pushes
    drops = 0;
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      s = 2'($urandom_range(0, 2));
      d = {$urandom, $urandom, $urandom};
      xfer(1'b1, d, s, pick(d, s), 1'b0, acc);
      if (!acc) drops++;
    end
    check("tput_in_ready_drops", 64'(drops), 64'd0);
    tick();
    tick();
    check("tput_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Random stall: 50% valid and 50% ready, including out-of-range selects
    for (int i = 0; i < 1000; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      s = 2'($urandom_range(0, 3));
      d = {$urandom, $urandom, $urandom};
      xfer(1'($urandom_range(0, 1)), d, s, pick(d, s), (s == 2'd3), acc);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (exp_q.size() == 0 && !o_out_valid) break;
      tick();
    end
    check("stall_drain_queue", 64'(exp_q.size()), 64'd0);
    check("stall_drain_valid", {63'd0, o_out_valid}, 64'd0);

    // Reset mid-operation while FULL
    out_ready = 1'b0;
    xfer(1'b1, w3(32'd30, 32'd20, 32'd10), 2'd0, 32'd10, 1'b0, acc);
    xfer(1'b1, w3(32'd30, 32'd20, 32'd10), 2'd1, 32'd20, 1'b0, acc);
    check("mid_full_in_ready", {63'd0, o_in_ready}, 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {63'd0, o_out_valid}, 64'd0);
    check("mid_rst_out_data", {32'd0, o_out_data}, 64'd0);
    check("mid_rst_sel_err", {63'd0, o_sel_err}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    pops_before = pop_count;
    out_ready = 1'b1;
    xfer(1'b1, w3(32'd33, 32'd22, 32'd11), 2'd2, 32'd33, 1'b0, acc);
    repeat (3) tick();
    check("mid_single_pop", 64'(pop_count - pops_before), 64'd1);
    check("mid_scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Power-of-two N: sel=3 is a real channel
    in_data4  = {32'd40, 32'd30, 32'd20, 32'd10};
    sel4      = 2'd3;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    check("n4_out_valid", {63'd0, o_out_valid4}, 64'd1);
    check("n4_sel3_data", {32'd0, o_out_data4}, 64'd40);
    check("n4_sel3_err", {63'd0, o_out_err4}, 64'd0);
    check("n4_sel_err", {63'd0, o_sel_err4}, 64'd0);
    sel4      = 2'd0;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    check("n4_sel0_data", {32'd0, o_out_data4}, 64'd10);
    sel4      = 2'd2;
    in_valid4 = 1'b1;
    tick();
    in_valid4 = 1'b0;
    check("n4_sel2_data", {32'd0, o_out_data4}, 64'd30);
    tick();
    check("n4_drained", {63'd0, o_out_valid4}, 64'd0);
    check("n4_sel_err_final", {63'd0, o_sel_err4}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
